// File: rtl/cmp_pkg.sv
// Shared types and helpers for seq_mag_comparator.
// EARLY_EXIT_EN selects early-exit timing in the top level.
package cmp_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   typedef enum logic [1:0] {CMP_EQ, CMP_GT, CMP_LT} res_e;

   // Odd parity excludes 0 and 2 set bits; the AND term excludes all three.
   function automatic logic onehot3(
      input logic g,
      input logic l,
      input logic e
   );
      return (g ^ l ^ e) & ~(g & l & e);
   endfunction

endpackage

// File: rtl/seq_mag_comparator_if.sv
// Handshake and data bundle for seq_mag_comparator.
// Master drives operands and out_ready; slave returns the result.
interface seq_mag_comparator_if #(
   parameter int WIDTH = 32,
   parameter int SLICE = 4
);
   localparam int NCHUNK = WIDTH / SLICE;
   localparam int BW = $clog2(NCHUNK + 1);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             signed_mode;
   logic             casc_gt;
   logic             casc_lt;
   logic             casc_eq;
   logic             out_valid;
   logic             out_ready;
   logic             res_gt;
   logic             res_lt;
   logic             res_eq;
   logic             casc_err;
   logic [BW-1:0]    busy_cycles;

   modport master (
      output in_valid, a, b, signed_mode,
      output casc_gt, casc_lt, casc_eq, out_ready,
      input  in_ready, out_valid, res_gt, res_lt,
      input  res_eq, casc_err, busy_cycles
   );

   modport slave (
      input  in_valid, a, b, signed_mode,
      input  casc_gt, casc_lt, casc_eq, out_ready,
      output in_ready, out_valid, res_gt, res_lt,
      output res_eq, casc_err, busy_cycles
   );

endinterface

// File: rtl/cmp_slice.sv
// Combinational SLICE-bit magnitude compare.
// msb_invert flips both MSBs so a two's-complement top chunk orders correctly.
module cmp_slice #(
   parameter int SLICE = 4
) (
   input  logic [SLICE-1:0] a_i,
   input  logic [SLICE-1:0] b_i,
   input  logic             msb_invert,
   output logic             gt,
   output logic             lt,
   output logic             eq
);

   logic [SLICE-1:0] ax;
   logic [SLICE-1:0] bx;

   always_comb begin
      ax = a_i;
      bx = b_i;
      ax[SLICE-1] = a_i[SLICE-1] ^ msb_invert;
      bx[SLICE-1] = b_i[SLICE-1] ^ msb_invert;
   end

   assign gt = (ax > bx);
   assign lt = (ax < bx);
   assign eq = (ax == bx);

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator with cascade tie-break.
// EARLY_EXIT_EN: leave RUN on the first differing chunk.
module seq_mag_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SLICE = 4
) (
   input logic                clk,
   input logic                rst_n,
   seq_mag_comparator_if.slave bus
);

   localparam int NCHUNK = WIDTH / SLICE;
   localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int BW = $clog2(NCHUNK + 1);

   state_e           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             sm_q, sm_d;
   logic             cg_q, cg_d;
   logic             cl_q, cl_d;
   logic             ce_q, ce_d;
   res_e             res_q, res_d;
   logic             err_q, err_d;
   logic [BW-1:0]    busy_q, busy_d;
`ifndef EARLY_EXIT_EN
   logic             hit_q, hit_d;
   res_e             hres_q, hres_d;
`endif

   logic [SLICE-1:0] ca;
   logic [SLICE-1:0] cb;
   logic             msb_inv;
   logic             s_gt;
   logic             s_lt;
   logic             s_eq;
   res_e             diff_res;
   res_e             casc_res;
   logic             casc_bad;

   assign ca = a_q[k_q*SLICE +: SLICE];
   assign cb = b_q[k_q*SLICE +: SLICE];
   assign msb_inv = sm_q && (k_q == KW'(NCHUNK - 1));

   cmp_slice #(.SLICE(SLICE)) u_slice (
      .a_i       (ca),
      .b_i       (cb),
      .msb_invert(msb_inv),
      .gt        (s_gt),
      .lt        (s_lt),
      .eq        (s_eq)
   );

   assign diff_res = s_gt ? CMP_GT : CMP_LT;

   always_comb begin
      casc_res = CMP_EQ;
      casc_bad = 1'b0;
      if (!onehot3(cg_q, cl_q, ce_q)) casc_bad = 1'b1;
      else if (cg_q)                  casc_res = CMP_GT;
      else if (cl_q)                  casc_res = CMP_LT;
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      a_d     = a_q;
      b_d     = b_q;
      sm_d    = sm_q;
      cg_d    = cg_q;
      cl_d    = cl_q;
      ce_d    = ce_q;
      res_d   = res_q;
      err_d   = err_q;
      busy_d  = busy_q;
`ifndef EARLY_EXIT_EN
      hit_d   = hit_q;
      hres_d  = hres_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               sm_d    = bus.signed_mode;
               cg_d    = bus.casc_gt;
               cl_d    = bus.casc_lt;
               ce_d    = bus.casc_eq;
               k_d     = KW'(NCHUNK - 1);
`ifndef EARLY_EXIT_EN
               hit_d   = 1'b0;
`endif
               state_d = RUN;
            end
         end
         RUN: begin
`ifdef EARLY_EXIT_EN
            if (!s_eq) begin
               res_d   = diff_res;
               err_d   = 1'b0;
               busy_d  = BW'(NCHUNK) - BW'(k_q);
               state_d = DONE;
            end else if (k_q == '0) begin
               res_d   = casc_res;
               err_d   = casc_bad;
               busy_d  = BW'(NCHUNK);
               state_d = DONE;
            end else begin
               k_d = k_q - KW'(1);
            end
`else
            if (!hit_q && !s_eq) begin
               hit_d  = 1'b1;
               hres_d = diff_res;
            end
            if (k_q == '0) begin
               busy_d  = BW'(NCHUNK);
               state_d = DONE;
               if (hit_q) begin
                  res_d = hres_q;
                  err_d = 1'b0;
               end else if (!s_eq) begin
                  res_d = diff_res;
                  err_d = 1'b0;
               end else begin
                  res_d = casc_res;
                  err_d = casc_bad;
               end
            end else begin
               k_d = k_q - KW'(1);
            end
`endif
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sm_q    <= 1'b0;
         cg_q    <= 1'b0;
         cl_q    <= 1'b0;
         ce_q    <= 1'b0;
         res_q   <= CMP_EQ;
         err_q   <= 1'b0;
         busy_q  <= '0;
`ifndef EARLY_EXIT_EN
         hit_q   <= 1'b0;
         hres_q  <= CMP_EQ;
`endif
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sm_q    <= sm_d;
         cg_q    <= cg_d;
         cl_q    <= cl_d;
         ce_q    <= ce_d;
         res_q   <= res_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
`ifndef EARLY_EXIT_EN
         hit_q   <= hit_d;
         hres_q  <= hres_d;
`endif
      end
   end

   assign bus.in_ready    = (state_q == IDLE);
   assign bus.out_valid   = (state_q == DONE);
   assign bus.res_gt      = (res_q == CMP_GT);
   assign bus.res_lt      = (res_q == CMP_LT);
   assign bus.res_eq      = (res_q == CMP_EQ);
   assign bus.casc_err    = err_q;
   assign bus.busy_cycles = busy_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed-vector bench for seq_mag_comparator, WIDTH=32, SLICE=4.
// Honours EARLY_EXIT_EN for expected latency and busy_cycles.
module tb_seq_mag_comparator;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad = 0;

`ifdef EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   always #5 clk = ~clk;

   seq_mag_comparator_if #(.WIDTH(32), .SLICE(4)) bus ();

   seq_mag_comparator #(.WIDTH(32), .SLICE(4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: sim time exceeded");
      $fatal(1);
   end

   task automatic run_txn(
      input  logic [31:0] a,
      input  logic [31:0] b,
      input  logic        sm,
      input  logic [2:0]  casc,
      output int          lat
   );
      int w = 0;
      while (!bus.in_ready && w < 20) begin
         @(posedge clk); #1; w++;
      end
      bus.a = a;
      bus.b = b;
      bus.signed_mode = sm;
      {bus.casc_gt, bus.casc_lt, bus.casc_eq} = casc;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      if (!bus.out_valid) lat = 0;
   endtask

   task automatic release_txn();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_hs: got rdy=%b vld=%b want 1/0", bus.in_ready, bus.out_valid);
      end
      total++;
      if ({bus.res_gt, bus.res_lt, bus.res_eq} !== 3'b001) begin
         bad++;
         $display("FAIL reset_res: got %b want 001", {bus.res_gt, bus.res_lt, bus.res_eq});
      end
      total++;
      if (bus.casc_err !== 1'b0 || bus.busy_cycles !== 4'd0) begin
         bad++;
         $display("FAIL reset_misc: got err=%b busy=%0d want 0/0", bus.casc_err, bus.busy_cycles);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_msb_diff();
      int lat;
      int el = EE ? 2 : 9;
      logic [3:0] eb = EE ? 4'd1 : 4'd8;
      run_txn(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b001, lat);
      total++;
      if (lat != el) begin
         bad++;
         $display("FAIL msb_lat: got %0d want %0d", lat, el);
      end
      total++;
      if ({bus.res_gt, bus.res_lt, bus.res_eq} !== 3'b100) begin
         bad++;
         $display("FAIL msb_res: got %b want 100", {bus.res_gt, bus.res_lt, bus.res_eq});
      end
      total++;
      if (bus.busy_cycles !== eb) begin
         bad++;
         $display("FAIL msb_busy: got %0d want %0d", bus.busy_cycles, eb);
      end
      release_txn();
   endtask

   task automatic test_cascade();
      logic [2:0] casc[3] = '{3'b001, 3'b100, 3'b110};
      logic [2:0] eres[3] = '{3'b001, 3'b100, 3'b001};
      logic       eerr[3] = '{1'b0, 1'b0, 1'b1};
      int lat;
      for (int i = 0; i < 3; i++) begin
         run_txn(32'h1234_5678, 32'h1234_5678, 1'b0, casc[i], lat);
         total++;
         if (lat != 9) begin
            bad++;
            $display("FAIL casc%0d_lat: got %0d want 9", i, lat);
         end
         total++;
         if ({bus.res_gt, bus.res_lt, bus.res_eq} !== eres[i]) begin
            bad++;
            $display("FAIL casc%0d_res: got %b want %b", i,
                     {bus.res_gt, bus.res_lt, bus.res_eq}, eres[i]);
         end
         total++;
         if (bus.casc_err !== eerr[i] || bus.busy_cycles !== 4'd8) begin
            bad++;
            $display("FAIL casc%0d_err: got err=%b busy=%0d want %b/8", i,
                     bus.casc_err, bus.busy_cycles, eerr[i]);
         end
         release_txn();
      end
   endtask

   task automatic test_signed();
      logic       smode[2] = '{1'b1, 1'b0};
      logic [2:0] eres[2] = '{3'b010, 3'b100};
      int el = EE ? 2 : 9;
      int lat;
      for (int i = 0; i < 2; i++) begin
         run_txn(32'hFFFF_FFFF, 32'h0000_0001, smode[i], 3'b001, lat);
         total++;
         if (lat != el) begin
            bad++;
            $display("FAIL sgn%0d_lat: got %0d want %0d", i, lat, el);
         end
         total++;
         if ({bus.res_gt, bus.res_lt, bus.res_eq} !== eres[i]) begin
            bad++;
            $display("FAIL sgn%0d_res: got %b want %b", i,
                     {bus.res_gt, bus.res_lt, bus.res_eq}, eres[i]);
         end
         release_txn();
      end
   endtask

   task automatic test_latency();
      int lat;
      run_txn(32'h0000_0010, 32'h0000_0011, 1'b0, 3'b100, lat);
      total++;
      if (lat != 9) begin
         bad++;
         $display("FAIL lsb_lat: got %0d want 9", lat);
      end
      total++;
      if ({bus.res_gt, bus.res_lt, bus.res_eq} !== 3'b010) begin
         bad++;
         $display("FAIL lsb_res: got %b want 010", {bus.res_gt, bus.res_lt, bus.res_eq});
      end
      total++;
      if (bus.busy_cycles !== 4'd8 || bus.casc_err !== 1'b0) begin
         bad++;
         $display("FAIL lsb_busy: got busy=%0d err=%b want 8/0", bus.busy_cycles, bus.casc_err);
      end
      release_txn();
   endtask

   task automatic test_backpressure();
      int lat;
      run_txn(32'h0000_0005, 32'h0000_0003, 1'b0, 3'b001, lat);
      total++;
      if (lat != 9) begin
         bad++;
         $display("FAIL bp_lat: got %0d want 9", lat);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         total++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
             {bus.res_gt, bus.res_lt, bus.res_eq} !== 3'b100) begin
            bad++;
            $display("FAIL bp_hold%0d: got vld=%b rdy=%b res=%b want 1/0/100", i,
                     bus.out_valid, bus.in_ready, {bus.res_gt, bus.res_lt, bus.res_eq});
         end
      end
      release_txn();
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_release: got vld=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready);
      end
      total++;
      if ({bus.res_gt, bus.res_lt, bus.res_eq} !== 3'b100) begin
         bad++;
         $display("FAIL bp_keep: got %b want 100", {bus.res_gt, bus.res_lt, bus.res_eq});
      end
   endtask

   task automatic test_reset_mid_run();
      int lat;
      bus.a = 32'h0000_0001;
      bus.b = 32'h0000_0000;
      bus.signed_mode = 1'b0;
      {bus.casc_gt, bus.casc_lt, bus.casc_eq} = 3'b001;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      total++;
      if (bus.in_ready !== 1'b0) begin
         bad++;
         $display("FAIL rr_run: got rdy=%b want 0", bus.in_ready);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL rr_hs: got vld=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready);
      end
      total++;
      if ({bus.res_gt, bus.res_lt, bus.res_eq} !== 3'b001 || bus.busy_cycles !== 4'd0) begin
         bad++;
         $display("FAIL rr_res: got res=%b busy=%0d want 001/0",
                  {bus.res_gt, bus.res_lt, bus.res_eq}, bus.busy_cycles);
      end
      run_txn(32'h0000_0003, 32'h0000_0009, 1'b0, 3'b001, lat);
      total++;
      if (lat != 9 || {bus.res_gt, bus.res_lt, bus.res_eq} !== 3'b010) begin
         bad++;
         $display("FAIL rr_next: got lat=%0d res=%b want 9/010", lat,
                  {bus.res_gt, bus.res_lt, bus.res_eq});
      end
      release_txn();
   endtask

   initial begin
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.signed_mode = 1'b0;
      bus.casc_gt = 1'b0;
      bus.casc_lt = 1'b0;
      bus.casc_eq = 1'b0;
      test_reset();
      test_msb_diff();
      test_cascade();
      test_signed();
      test_latency();
      test_backpressure();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
